// File: rtl/difficulty_ramp_pkg.sv
// Shared game-timing constants for the plane game difficulty ramp.
// Default floors, ceilings and step periods used by difficulty_ramp.
package difficulty_ramp_pkg;
   localparam int CLK_HZ          = 50_000_000;
   localparam int AMT_W_DEF       = 4;
   localparam int AMT_MIN_DEF     = 1;
   localparam int AMT_MAX_DEF     = 10;
   localparam int AMT_PERIOD_DEF  = 10 * CLK_HZ;
   localparam int RATE_W_DEF      = 2;
   localparam int RATE_MIN_DEF    = 0;
   localparam int RATE_MAX_DEF    = 3;
   localparam int RATE_PERIOD_DEF = 10 * CLK_HZ;
endpackage

// File: rtl/ramp_channel.sv
// One saturating difficulty channel: a free-running period timer that bumps
// the value once per period until it reaches its ceiling.
module ramp_channel #(
   parameter int W      = 4,
   parameter int MIN    = 1,
   parameter int MAX    = 10,
   parameter int PERIOD = 4
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         enable,
   input  logic         restart,
   output logic [W-1:0] value,
   output logic         step,
   output logic         at_max
);
   localparam int             TW         = $clog2(PERIOD + 1);
   localparam logic [TW-1:0]  TMR_LAST   = TW'(PERIOD - 1);
   localparam logic [W-1:0]   VMIN       = W'(MIN);
   localparam logic [W-1:0]   VMAX       = W'(MAX);
   localparam logic           AT_MAX_RST = (MIN == MAX);

   logic [TW-1:0] tmr_q, tmr_d;
   logic [W-1:0]  val_q, val_d;
   logic          step_q, step_d;
   logic          max_q, max_d;
   logic          wrap;

   assign wrap = (tmr_q == TMR_LAST);

   always_comb begin
      tmr_d  = tmr_q;
      val_d  = val_q;
      step_d = 1'b0;
      max_d  = max_q;
      if (restart) begin
         tmr_d = '0;
         val_d = VMIN;
         max_d = AT_MAX_RST;
      end else if (enable) begin
         tmr_d = wrap ? '0 : tmr_q + TW'(1);
         // Timer keeps cycling at the ceiling; only the value stops moving.
         if (wrap && (val_q != VMAX)) begin
            val_d  = val_q + W'(1);
            step_d = 1'b1;
         end
         max_d = (val_d == VMAX);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tmr_q  <= '0;
         val_q  <= VMIN;
         step_q <= 1'b0;
         max_q  <= AT_MAX_RST;
      end else begin
         tmr_q  <= tmr_d;
         val_q  <= val_d;
         step_q <= step_d;
         max_q  <= max_d;
      end
   end

   assign value  = val_q;
   assign step   = step_q;
   assign at_max = max_q;
endmodule

// File: rtl/difficulty_ramp.sv
// Game-difficulty ramp: two independent saturating channels (plane count and
// flying speed) advanced while the game FSM holds enable high.
module difficulty_ramp
   import difficulty_ramp_pkg::*;
#(
   parameter int AMT_W       = AMT_W_DEF,
   parameter int AMT_MIN     = AMT_MIN_DEF,
   parameter int AMT_MAX     = AMT_MAX_DEF,
   parameter int AMT_PERIOD  = AMT_PERIOD_DEF,
   parameter int RATE_W      = RATE_W_DEF,
   parameter int RATE_MIN    = RATE_MIN_DEF,
   parameter int RATE_MAX    = RATE_MAX_DEF,
   parameter int RATE_PERIOD = RATE_PERIOD_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic              restart,
   output logic [AMT_W-1:0]  plane_amount,
   output logic [RATE_W-1:0] flying_rate,
   output logic              amt_step,
   output logic              rate_step,
   output logic              max_level
);
   logic amt_at_max, rate_at_max;

   ramp_channel #(.W(AMT_W), .MIN(AMT_MIN), .MAX(AMT_MAX), .PERIOD(AMT_PERIOD)) u_amt (
      .clk     (clk),
      .resetn  (resetn),
      .enable  (enable),
      .restart (restart),
      .value   (plane_amount),
      .step    (amt_step),
      .at_max  (amt_at_max)
   );

   ramp_channel #(.W(RATE_W), .MIN(RATE_MIN), .MAX(RATE_MAX), .PERIOD(RATE_PERIOD)) u_rate (
      .clk     (clk),
      .resetn  (resetn),
      .enable  (enable),
      .restart (restart),
      .value   (flying_rate),
      .step    (rate_step),
      .at_max  (rate_at_max)
   );

   // Both flags are flops, so this AND has no path from the inputs.
   assign max_level = amt_at_max & rate_at_max;
endmodule
